// File: rtl/video_mode_pkg.sv
// video_mode_pkg: mode codes, FSM states and timing parameter sets for video_mode_ctrl
package video_mode_pkg;
  localparam logic [1:0] MODE_1080P = 2'd0;
  localparam logic [1:0] MODE_1600P = 2'd1;
  localparam logic [1:0] MODE_720P = 2'd2;
  localparam logic [1:0] MODE_INV = 2'd3;
  typedef enum logic [1:0] {S_HOLD, S_RUN, S_DEBOUNCE, S_PENDING} state_t;
  typedef struct packed {
    logic [11:0] v_total, v_fp, v_bp, v_sync, v_act;
    logic [11:0] h_total, h_fp, h_bp, h_sync, h_act;
  } timing_t;
  localparam timing_t TIMING_1080P = '{12'd1125, 12'd4, 12'd36, 12'd5, 12'd1080,
                                       12'd2200, 12'd88, 12'd148, 12'd44, 12'd1920};
  localparam timing_t TIMING_1600P = '{12'd1646, 12'd3, 12'd37, 12'd6, 12'd1600,
                                       12'd2720, 12'd48, 12'd80, 12'd32, 12'd2560};
  localparam timing_t TIMING_720P = '{12'd750, 12'd5, 12'd20, 12'd5, 12'd720,
                                      12'd1650, 12'd110, 12'd220, 12'd40, 12'd1280};
  function automatic timing_t mode_timing(input logic [1:0] mode);
    return mode == MODE_1600P ? TIMING_1600P : mode == MODE_720P ? TIMING_720P : TIMING_1080P;
  endfunction
endpackage

// File: rtl/mode_debounce.sv
// mode_debounce: synchronizes mode_req and reports when a candidate mode has been stable long enough
module mode_debounce
  import video_mode_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES = 16'd1024
) (
  input  logic       pix_clk,
  input  logic       rst,
  input  logic [1:0] mode_req,
  input  logic       restart,
  output logic [1:0] req_s,
  output logic [1:0] stable_mode,
  output logic       stable_valid
);
  logic [1:0]  req_m;
  logic [15:0] cnt;
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      req_m       <= MODE_1080P;
      req_s       <= MODE_1080P;
      stable_mode <= MODE_1080P;
      cnt         <= '0;
    end else begin
      req_m <= mode_req;
      req_s <= req_m;
      if (restart || req_s != stable_mode) begin
        stable_mode <= req_s;
        cnt         <= '0;
      end else if (cnt != DEB_CYCLES - 16'd1) begin
        cnt <= cnt + 16'd1;
      end
    end
  end
  assign stable_valid = cnt == DEB_CYCLES - 16'd1 && req_s == stable_mode;
endmodule

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: switches sync/pattern generator timing at a frame boundary with a held reset
module video_mode_ctrl
  import video_mode_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES     = 16'd1024,
  parameter logic [7:0]  HOLD_CYCLES    = 8'd16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_000_000
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic [1:0]  mode_req,
  input  logic        vs_in,
  output logic [11:0] v_total,
  output logic [11:0] v_fp,
  output logic [11:0] v_bp,
  output logic [11:0] v_sync,
  output logic [11:0] v_act,
  output logic [11:0] h_total,
  output logic [11:0] h_fp,
  output logic [11:0] h_bp,
  output logic [11:0] h_sync,
  output logic [11:0] h_act,
  output logic        timing_rstn,
  output logic [1:0]  mode_cur,
  output logic        busy,
  output logic        mode_err
);
  state_t      state;
  timing_t     par;
  logic        vs_d;
  logic        err_lock;
  logic [23:0] tcnt;
  logic [7:0]  hcnt;
  logic [1:0]  req_s;
  logic [1:0]  cand;
  logic        stable_valid;
  mode_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .pix_clk      (pix_clk),
    .rst          (rst),
    .mode_req     (mode_req),
    .restart      (state == S_RUN || state == S_HOLD),
    .req_s        (req_s),
    .stable_mode  (cand),
    .stable_valid (stable_valid)
  );
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state    <= S_HOLD;
      par      <= TIMING_1080P;
      mode_cur <= MODE_1080P;
      mode_err <= 1'b0;
      vs_d     <= 1'b0;
      err_lock <= 1'b0;
      tcnt     <= '0;
      hcnt     <= '0;
    end else begin
      vs_d     <= vs_in;
      mode_err <= 1'b0;
      if (req_s != MODE_INV) err_lock <= 1'b0;
      case (state)
        S_RUN: begin
          if (req_s != mode_cur && !(err_lock && req_s == MODE_INV)) state <= S_DEBOUNCE;
        end
        S_DEBOUNCE: begin
          if (req_s == mode_cur) begin
            state <= S_RUN;
          end else if (stable_valid && cand == MODE_INV) begin
            mode_err <= 1'b1;
            err_lock <= 1'b1;
            state    <= S_RUN;
          end else if (stable_valid) begin
            tcnt  <= '0;
            state <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (req_s != cand) begin
            state <= S_DEBOUNCE;
          end else if ((vs_in && !vs_d) || tcnt == TIMEOUT_CYCLES - 24'd1) begin
            state    <= S_HOLD;
            mode_cur <= cand;
            par      <= mode_timing(cand);
            hcnt     <= '0;
          end else begin
            tcnt <= tcnt + 24'd1;
          end
        end
        default: begin
          if (hcnt == HOLD_CYCLES - 8'd1) state <= S_RUN;
          else hcnt <= hcnt + 8'd1;
        end
      endcase
    end
  end
  assign {v_total, v_fp, v_bp, v_sync, v_act, h_total, h_fp, h_bp, h_sync, h_act} = par;
  assign timing_rstn = state != S_HOLD;
  assign busy = state != S_RUN;
endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb_video_mode_ctrl: directed scoreboard bench for mode switching, debounce, timeout and hold timing
module tb_video_mode_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode_req = 2'd0;
  logic        vs_in = 1'b0;
  logic [11:0] v_total, v_fp, v_bp, v_sync, v_act, h_total, h_fp, h_bp, h_sync, h_act;
  logic        timing_rstn, busy, mode_err;
  logic [1:0]  mode_cur;
  int          total = 0;
  int          bad = 0;
  int          err_cnt = 0;
  int          low_len = 0;
  int          err_base;
  logic        prev_rstn = 1'b0;
  int          exp_q[$];
  logic [119:0] dut_par, exp_v;
  int          exp_m;

  video_mode_ctrl #(.DEB_CYCLES(16'd8), .HOLD_CYCLES(8'd16), .TIMEOUT_CYCLES(24'd50)) dut (
    .pix_clk     (clk),
    .rst         (rst),
    .mode_req    (mode_req),
    .vs_in       (vs_in),
    .v_total     (v_total),
    .v_fp        (v_fp),
    .v_bp        (v_bp),
    .v_sync      (v_sync),
    .v_act       (v_act),
    .h_total     (h_total),
    .h_fp        (h_fp),
    .h_bp        (h_bp),
    .h_sync      (h_sync),
    .h_act       (h_act),
    .timing_rstn (timing_rstn),
    .mode_cur    (mode_cur),
    .busy        (busy),
    .mode_err    (mode_err)
  );

  always #5 clk = ~clk;

  function automatic logic [119:0] exp_par(input int m);
    case (m)
      1: return {12'd1646, 12'd3, 12'd37, 12'd6, 12'd1600, 12'd2720, 12'd48, 12'd80, 12'd32, 12'd2560};
      2: return {12'd750, 12'd5, 12'd20, 12'd5, 12'd720, 12'd1650, 12'd110, 12'd220, 12'd40, 12'd1280};
      default: return {12'd1125, 12'd4, 12'd36, 12'd5, 12'd1080, 12'd2200, 12'd88, 12'd148, 12'd44, 12'd1920};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_rstn(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (timing_rstn !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, timing_rstn}, {31'd0, lvl});
  endtask

  task automatic vs_pulse();
    @(posedge clk) #1 vs_in = 1'b1;
    @(posedge clk) #1 vs_in = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      low_len = 0;
    end else begin
      if (timing_rstn === 1'b0) low_len++;
      if (prev_rstn === 1'b1 && timing_rstn === 1'b0) begin
        check("hold_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_m = exp_q.pop_front();
          exp_v = exp_par(exp_m);
          dut_par = {v_total, v_fp, v_bp, v_sync, v_act, h_total, h_fp, h_bp, h_sync, h_act};
          check("sw_mode", {30'd0, mode_cur}, exp_m);
          for (int i = 0; i < 10; i++)
            check($sformatf("sw_par%0d_m%0d", i, exp_m), {20'd0, dut_par[i*12 +: 12]}, {20'd0, exp_v[i*12 +: 12]});
        end
      end
      if (prev_rstn === 1'b0 && timing_rstn === 1'b1) begin
        check("hold_len", low_len, 16);
        check("busy_at_rise", {31'd0, busy}, 32'd0);
        low_len = 0;
      end
    end
    if (mode_err === 1'b1) err_cnt++;
    prev_rstn = timing_rstn;
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rstn", {31'd0, timing_rstn}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_mode", {30'd0, mode_cur}, 32'd0);
    check("rst_err", {31'd0, mode_err}, 32'd0);
    check("rst_v_act", {20'd0, v_act}, 32'd1080);
    @(posedge clk) #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("rel_rstn_low16", {31'd0, timing_rstn}, 32'd0);
    @(negedge clk);
    check("rel_rstn_high", {31'd0, timing_rstn}, 32'd1);
    check("rel_busy", {31'd0, busy}, 32'd0);
    check("rel_v_act", {20'd0, v_act}, 32'd1080);
    check("rel_h_total", {20'd0, h_total}, 32'd2200);
    check("rel_mode", {30'd0, mode_cur}, 32'd0);

    @(posedge clk) #1 mode_req = 2'd1;
    exp_q.push_back(1);
    repeat (29) @(posedge clk);
    #1 vs_in = 1'b1;
    @(negedge clk);
    check("m1_pre_edge_rstn", {31'd0, timing_rstn}, 32'd1);
    check("m1_pending_busy", {31'd0, busy}, 32'd1);
    @(posedge clk) #1 vs_in = 1'b0;
    @(negedge clk);
    check("m1_edge_rstn", {31'd0, timing_rstn}, 32'd0);
    wait_rstn(1'b1, 30, "m1_release");
    check("m1_v_total", {20'd0, v_total}, 32'd1646);
    check("m1_h_act", {20'd0, h_act}, 32'd2560);
    check("m1_mode", {30'd0, mode_cur}, 32'd1);

    @(posedge clk) #1 mode_req = 2'd2;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("gl_busy_high", {31'd0, busy}, 32'd1);
    @(posedge clk) #1 mode_req = 2'd1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("gl_busy", {31'd0, busy}, 32'd0);
    check("gl_mode", {30'd0, mode_cur}, 32'd1);
    check("gl_v_total", {20'd0, v_total}, 32'd1646);

    err_base = err_cnt;
    @(posedge clk) #1 mode_req = 2'd3;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("inv_err_pulses", err_cnt - err_base, 1);
    check("inv_mode", {30'd0, mode_cur}, 32'd1);
    check("inv_busy", {31'd0, busy}, 32'd0);
    check("inv_rstn", {31'd0, timing_rstn}, 32'd1);
    @(posedge clk) #1 mode_req = 2'd1;
    repeat (5) @(posedge clk);

    @(posedge clk) #1 mode_req = 2'd2;
    exp_q.push_back(2);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("to_pre_rstn", {31'd0, timing_rstn}, 32'd1);
    @(negedge clk);
    check("to_rstn_low", {31'd0, timing_rstn}, 32'd0);
    wait_rstn(1'b1, 30, "to_release");
    check("to_v_act", {20'd0, v_act}, 32'd720);
    check("to_mode", {30'd0, mode_cur}, 32'd2);

    @(posedge clk) #1 mode_req = 2'd0;
    repeat (20) @(posedge clk);
    #1 mode_req = 2'd1;
    exp_q.push_back(1);
    repeat (5) @(posedge clk);
    vs_pulse();
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("pd_vs_ignored_rstn", {31'd0, timing_rstn}, 32'd1);
    check("pd_busy", {31'd0, busy}, 32'd1);
    repeat (9) @(posedge clk);
    vs_pulse();
    wait_rstn(1'b0, 5, "pd_hold");
    wait_rstn(1'b1, 30, "pd_release");
    check("pd_mode", {30'd0, mode_cur}, 32'd1);
    check("pd_v_total", {20'd0, v_total}, 32'd1646);

    @(posedge clk) #1 mode_req = 2'd2;
    exp_q.push_back(2);
    repeat (20) @(posedge clk);
    vs_pulse();
    wait_rstn(1'b0, 5, "hd_hold1");
    @(posedge clk) #1 mode_req = 2'd0;
    exp_q.push_back(0);
    wait_rstn(1'b1, 30, "hd_release1");
    check("hd_mode_first", {30'd0, mode_cur}, 32'd2);
    check("hd_v_act_first", {20'd0, v_act}, 32'd720);
    wait_rstn(1'b0, 100, "hd_hold2");
    wait_rstn(1'b1, 30, "hd_release2");
    check("hd_mode_final", {30'd0, mode_cur}, 32'd0);
    check("hd_v_act_final", {20'd0, v_act}, 32'd1080);
    check("hd_h_total_final", {20'd0, h_total}, 32'd2200);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
